// File: rtl/ddr3_arb_pkg.sv
// Shared encodings for the DDR3 read/write port arbiter.
package ddr3_arb_pkg;

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_IDLE = 2'd1,
        S_WR   = 2'd2,
        S_RD   = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_WR = 1'b0,
        OWN_RD = 1'b1
    } owner_t;

    localparam int RUN_CNT_MAX = 15;
    localparam int RUN_CNT_W   = 4;

endpackage

// File: rtl/ddr3_arb_watchdog.sv
// Per-burst watchdog: clears when a grant is issued, counts while a grant is
// held and flags expiry on the cycle the count reaches TIMEOUT_CYCLES-1.
// Only instantiated when DDR3_ARB_WATCHDOG_EN is defined.
module ddr3_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    input  logic active,
    input  logic done,
    output logic expire
);

    localparam int W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt;

    // Cycle counter: restart on grant entry, advance while the grant is held
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (start)
            cnt <= '0;
        else if (active)
            cnt <= cnt + 1'b1;
    end

    // A done pulse in the expiry cycle counts as a normal completion
    assign expire = active && (cnt == LIMIT) && !done;

endmodule

// File: rtl/ddr3_rw_arbiter.sv
// Burst-granular weighted round-robin arbiter sharing one DDR3 AXI port
// between the write bridge and the read bridge, gated by calibration.
// Optional per-burst watchdog: define DDR3_ARB_WATCHDOG_EN.
module ddr3_rw_arbiter
    import ddr3_arb_pkg::*;
#(
    parameter int WR_WEIGHT      = 4,
    parameter int RD_WEIGHT      = 4,
    parameter int CNT_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 init_calib_complete,
    input  logic                 wr_ddr3_req,
    input  logic                 rd_ddr3_req,
    input  logic                 wr_burst_done,
    input  logic                 rd_burst_done,
    output logic                 wr_grant,
    output logic                 rd_grant,
    output logic                 arb_busy,
    output logic [CNT_WIDTH-1:0] wr_burst_cnt,
    output logic [CNT_WIDTH-1:0] rd_burst_cnt,
    output logic                 err_timeout
);

    if (WR_WEIGHT < 1 || WR_WEIGHT > RUN_CNT_MAX || RD_WEIGHT < 1 ||
        RD_WEIGHT > RUN_CNT_MAX || CNT_WIDTH < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("ddr3_rw_arbiter: parameter out of range");
    end

    localparam logic [RUN_CNT_W-1:0] WR_W    = RUN_CNT_W'(WR_WEIGHT);
    localparam logic [RUN_CNT_W-1:0] RD_W    = RUN_CNT_W'(RD_WEIGHT);
    localparam logic [RUN_CNT_W-1:0] RUN_MAX = RUN_CNT_W'(RUN_CNT_MAX);

    arb_state_t           state, state_nxt;
    owner_t               last_owner, new_owner;
    logic [RUN_CNT_W-1:0] run_cnt, weight_last;
    logic                 keep_last, grant_start;
    logic                 wr_done_ok, rd_done_ok;
    logic                 wd_expire;

    assign wr_done_ok = (state == S_WR) && wr_burst_done;
    assign rd_done_ok = (state == S_RD) && rd_burst_done;

    // Tie-break: stay with the last owner while it still has run credit.
    // A zero run count means nobody has been served yet, so the tie goes
    // to the side opposite the reset owner.
    always_comb begin
        weight_last = (last_owner == OWN_WR) ? WR_W : RD_W;
        keep_last   = (run_cnt != '0) && (run_cnt < weight_last);
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT: if (init_calib_complete) state_nxt = S_IDLE;
            S_IDLE: begin
                if (!init_calib_complete)
                    state_nxt = S_INIT;
                else if (wr_ddr3_req && !rd_ddr3_req)
                    state_nxt = S_WR;
                else if (rd_ddr3_req && !wr_ddr3_req)
                    state_nxt = S_RD;
                else if (wr_ddr3_req && rd_ddr3_req) begin
                    if (keep_last)
                        state_nxt = (last_owner == OWN_WR) ? S_WR : S_RD;
                    else
                        state_nxt = (last_owner == OWN_WR) ? S_RD : S_WR;
                end
            end
            S_WR:   if (wr_burst_done || wd_expire) state_nxt = S_IDLE;
            S_RD:   if (rd_burst_done || wd_expire) state_nxt = S_IDLE;
            default: state_nxt = S_INIT;
        endcase
    end

    assign grant_start = (state == S_IDLE) && ((state_nxt == S_WR) || (state_nxt == S_RD));
    assign new_owner   = (state_nxt == S_RD) ? OWN_RD : OWN_WR;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= S_INIT;
        else
            state <= state_nxt;
    end

    // Registered grant outputs, decoded from the next state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_grant <= 1'b0;
            rd_grant <= 1'b0;
            arb_busy <= 1'b0;
        end else begin
            wr_grant <= (state_nxt == S_WR);
            rd_grant <= (state_nxt == S_RD);
            arb_busy <= (state_nxt == S_WR) || (state_nxt == S_RD);
        end
    end

    // Ownership history: run length of the current owner, saturating
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_owner <= OWN_RD;
            run_cnt    <= '0;
        end else if (grant_start) begin
            last_owner <= new_owner;
            if (new_owner == last_owner)
                run_cnt <= (run_cnt == RUN_MAX) ? run_cnt : run_cnt + 1'b1;
            else
                run_cnt <= RUN_CNT_W'(1);
        end else if (wd_expire) begin
            // Hung burst: hand preference to the other side
            last_owner <= (last_owner == OWN_WR) ? OWN_RD : OWN_WR;
            run_cnt    <= RUN_CNT_W'(1);
        end
    end

    // Completed-burst statistics, only for done pulses matching the grant
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_burst_cnt <= '0;
            rd_burst_cnt <= '0;
        end else begin
            if (wr_done_ok) wr_burst_cnt <= wr_burst_cnt + 1'b1;
            if (rd_done_ok) rd_burst_cnt <= rd_burst_cnt + 1'b1;
        end
    end

`ifdef DDR3_ARB_WATCHDOG_EN
    logic in_grant;
    assign in_grant = (state == S_WR) || (state == S_RD);

    ddr3_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (grant_start),
        .active  (in_grant),
        .done    (wr_done_ok || rd_done_ok),
        .expire  (wd_expire)
    );

    // Sticky timeout flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            err_timeout <= 1'b0;
        else if (wd_expire)
            err_timeout <= 1'b1;
    end
`else
    assign wd_expire   = 1'b0;
    assign err_timeout = 1'b0;
`endif

    // The two bridges must never own the port together
    a_grant_excl: assert property (@(posedge clk) disable iff (!reset_n) !(wr_grant && rd_grant));

endmodule

// File: tb/tb_ddr3_rw_arbiter.sv
// Scoreboard bench for ddr3_rw_arbiter: the stimulus thread predicts each
// grant owner from the arbitration rules and queues it; a monitor pops and
// compares on every grant rising edge. Watchdog checks run when the bench is
// built with DDR3_ARB_WATCHDOG_EN.
module tb_ddr3_rw_arbiter;

    localparam int WR_W = 4;
    localparam int RD_W = 4;
    localparam int CW   = 32;
    localparam int TO   = 64;

    logic          clk = 1'b0;
    logic          reset_n, cal, wr_req, rd_req, wr_done, rd_done;
    logic          wr_grant, rd_grant, arb_busy, err_timeout;
    logic [CW-1:0] wr_burst_cnt, rd_burst_cnt;

    ddr3_rw_arbiter #(
        .WR_WEIGHT(WR_W), .RD_WEIGHT(RD_W), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .init_calib_complete (cal),
        .wr_ddr3_req         (wr_req),
        .rd_ddr3_req         (rd_req),
        .wr_burst_done       (wr_done),
        .rd_burst_done       (rd_done),
        .wr_grant            (wr_grant),
        .rd_grant            (rd_grant),
        .arb_busy            (arb_busy),
        .wr_burst_cnt        (wr_burst_cnt),
        .rd_burst_cnt        (rd_burst_cnt),
        .err_timeout         (err_timeout)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int exp_q[$];

    // Reference model: owner 0 = write, 1 = read
    int m_last, m_run, m_wr_cnt, m_rd_cnt;

    function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endfunction

    function automatic void model_reset();
        m_last = 1; m_run = 0; m_wr_cnt = 0; m_rd_cnt = 0;
    endfunction

    // Who wins for a given request pair, and record the new streak
    function automatic int pick(input bit w, input bit r);
        int o, wt;
        if (w && !r) o = 0;
        else if (r && !w) o = 1;
        else begin
            wt = (m_last == 0) ? WR_W : RD_W;
            o  = (m_run > 0 && m_run < wt) ? m_last : 1 - m_last;
        end
        if (o == m_last) m_run = (m_run >= 15) ? 15 : m_run + 1;
        else m_run = 1;
        m_last = o;
        return o;
    endfunction

    task automatic check_cnt(input string tag);
        check({tag, "_wr_cnt"}, wr_burst_cnt, m_wr_cnt);
        check({tag, "_rd_cnt"}, rd_burst_cnt, m_rd_cnt);
    endtask

    // One burst issued from S_IDLE; the bench acts as the granted bridge
    task automatic burst(input bit w, input bit r, input int lat, input bit stray,
                         input bit drop, input bit caldrop, input int exp_wait);
        int n, o;
        bit gw;
        wr_req = w; rd_req = r;
        o = pick(w, r);
        exp_q.push_back(o);
        n = 0;
        while (!(wr_grant || rd_grant) && n < 20) begin
            @(negedge clk); n++;
        end
        check("grant_latency", n, exp_wait);
        if (!(wr_grant || rd_grant)) return;
        gw = wr_grant;
        check("busy_with_grant", arb_busy, 1);
        if (drop) begin wr_req = 0; rd_req = 0; end
        if (caldrop) cal = 0;
        repeat (lat) @(negedge clk);
        check("grant_hold", gw ? wr_grant : rd_grant, 1);
        if (gw) begin wr_done = 1; rd_done = stray; end
        else    begin rd_done = 1; wr_done = stray; end
        @(negedge clk);
        wr_done = 0; rd_done = 0;
        check("grant_fall", {wr_grant, rd_grant, arb_busy}, 0);
        if (o == 0) m_wr_cnt++; else m_rd_cnt++;
    endtask

    // Monitor: every new grant must match the oldest prediction
    bit pw = 0, pr = 0;
    initial begin
        forever begin
            @(negedge clk);
            check("grant_exclusive", wr_grant & rd_grant, 0);
            if ((wr_grant && !pw) || (rd_grant && !pr)) begin
                if (exp_q.size() == 0) check("grant_unexpected", 0, 1);
                else check("grant_owner", rd_grant ? 1 : 0, exp_q.pop_front());
            end
            pw = wr_grant; pr = rd_grant;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int nog, n, len, o;
        bit w, r;
        reset_n = 0; cal = 0; wr_req = 1; rd_req = 1; wr_done = 0; rd_done = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_outputs", {wr_grant, rd_grant, arb_busy, err_timeout}, 0);
        check_cnt("reset");
        reset_n = 1;

        // Calibration gating with both requesters waiting
        nog = 0;
        repeat (100) begin
            @(negedge clk);
            if (wr_grant || rd_grant) nog++;
        end
        check("calib_gate", nog, 0);
        cal = 1;
        burst(1, 1, 10, 0, 0, 0, 2);

        // Weighted fairness: WRx4, RDx4, WRx4
        for (int i = 0; i < 11; i++) burst(1, 1, 10, 0, 0, 0, 1);
        check("fair_wr_total", wr_burst_cnt, 8);
        check("fair_rd_total", rd_burst_cnt, 4);

        // Asynchronous reset in the middle of a write burst
        wr_req = 1; rd_req = 0;
        exp_q.push_back(pick(1, 0));
        n = 0;
        while (!wr_grant && n < 20) begin @(negedge clk); n++; end
        check("rst_burst_grant", wr_grant, 1);
        @(negedge clk);
        reset_n = 0;
        #1;
        check("rst_async_outputs", {wr_grant, rd_grant, arb_busy, err_timeout}, 0);
        check("rst_async_counts", {wr_burst_cnt, rd_burst_cnt}, 0);
        model_reset();
        @(negedge clk);
        reset_n = 1;

        // Sole read requester: 20 reads in a row, stray write dones ignored
        burst(0, 1, $urandom_range(0, 8), 1, 0, 0, 2);
        for (int i = 0; i < 19; i++)
            burst(0, 1, $urandom_range(0, 8), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 1);
        check("sole_rd_total", rd_burst_cnt, 20);
        check("sole_wr_total", wr_burst_cnt, 0);

        // Calibration loss mid-burst: burst completes, then back to init
        burst(1, 1, 6, 0, 0, 1, 1);
        nog = 0;
        repeat (10) begin
            @(negedge clk);
            if (wr_grant || rd_grant) nog++;
        end
        check("calib_lost_gate", nog, 0);
        cal = 1;
        burst(1, 1, 5, 0, 0, 0, 2);
        check_cnt("calib");

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            w = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            if (!w && !r) w = 1;
            burst(w, r, $urandom_range(0, 12), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 0, 1);
        end
        check_cnt("random");

`ifdef DDR3_ARB_WATCHDOG_EN
        // Hung burst: no done pulse, watchdog must reclaim the port
        wr_req = 1; rd_req = 1;
        o = pick(1, 1);
        exp_q.push_back(o);
        n = 0;
        while (!(wr_grant || rd_grant) && n < 20) begin @(negedge clk); n++; end
        check("wd_grant_latency", n, 1);
        len = 0;
        while ((wr_grant || rd_grant) && len < 200) begin @(negedge clk); len++; end
        check("wd_grant_len", len, TO);
        check("wd_err_set", err_timeout, 1);
        m_last = 1 - m_last; m_run = 1;
        burst(1, 1, 4, 0, 0, 0, 1);
        check("wd_err_sticky", err_timeout, 1);
        check_cnt("wd");
`else
        check("err_timeout_tied", err_timeout, 0);
`endif

        repeat (2) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ddr3_rw_arbiter.md
Name: ddr3_rw_arbiter

Overview:
Schedules the single DDR3 controller AXI4 port between the write bridge (FIFO→DDR, AW/W/B) and the read bridge (DDR→FIFO, AR/R).
- Grants whole bursts only. Exactly one bridge owns the port at any time.
- Weighted round-robin between bridges.
- Gated by memory calibration.
- Keeps per-direction burst statistics.

Parameters:
WR_WEIGHT, 4, max consecutive write bursts while a read request is pending (1..15)
RD_WEIGHT, 4, max consecutive read bursts while a write request is pending (1..15)
CNT_WIDTH, 32, width of burst statistic counters
TIMEOUT_CYCLES, 4096, watchdog limit in clk cycles per granted burst (only with WATCHDOG_EN)

Ports:
clk  in  1  system clock, same domain as the AXI bridges
reset_n  in  1  asynchronous active-low reset
init_calib_complete  in  1  DDR3 calibration done (synchronous to clk)
wr_ddr3_req  in  1  write bridge has ≥1 burst ready in its FIFO
rd_ddr3_req  in  1  read bridge has room for ≥1 burst
wr_burst_done  in  1  1-cycle pulse: B handshake with BRESP==OKAY
rd_burst_done  in  1  1-cycle pulse: R handshake with RLAST, RRESP==OKAY
wr_grant  out  1  write bridge may start/continue its burst
rd_grant  out  1  read bridge may start/continue its burst
arb_busy  out  1  a grant is active
wr_burst_cnt  out  CNT_WIDTH  completed write bursts, wraps
rd_burst_cnt  out  CNT_WIDTH  completed read bursts, wraps
err_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset values: all outputs 0. State S_INIT, run counter 0, last owner = RD, so the first tie goes to WR.
- States:
  - S_INIT: wait while init_calib_complete=0; go to S_IDLE when it is 1.
  - S_IDLE:
    - If init_calib_complete=0, return to S_INIT.
    - If only wr_ddr3_req=1, go to S_WR.
    - If only rd_ddr3_req=1, go to S_RD.
    - If both are 1, continue the last owner while its run count < its weight; otherwise switch.
    - If neither is 1, stay.
  - S_WR: wr_grant=1. On wr_burst_done, go to S_IDLE.
  - S_RD: rd_grant=1. On rd_burst_done, go to S_IDLE.
- Outputs are registered. Grant rises 1 cycle after the request is sampled in S_IDLE and falls 1 cycle after the done pulse. At least one S_IDLE cycle always separates two grants.
- wr_grant and rd_grant are never both 1; assertion checked in simulation.
- Run counter:
  - Increments when the same owner is granted again.
  - Resets to 1 when ownership switches.
  - Saturates at 15.
  - Weight limits apply only when the other side is requesting. A sole requester is served indefinitely.
- A grant is never revoked mid-burst by a request drop or by calibration loss. Calibration loss is handled after the current burst completes.
- Done pulses arriving in a state that does not match them are ignored. They must not bump counters.
- A request that drops before the grant is issued is ignored in S_IDLE.
- Statistics counters increment on the accepted done pulse and wrap modulo 2^CNT_WIDTH.
- reset_n low mid-burst immediately forces all outputs to their reset values. The bridges are reset by the same reset_n.

Optional Feature:
DDR3_ARB_WATCHDOG_EN
- With the macro:
  - A cycle counter clears on grant entry and counts while in S_WR or S_RD.
  - Reaching TIMEOUT_CYCLES-1 without a done pulse sets err_timeout (sticky until reset), drops the grant, returns to S_IDLE and switches the last owner.
  - A done pulse in the same cycle as the timeout wins: normal completion, no error.
- Without the macro: no counter logic; err_timeout is tied to 0.

Decomposition:
- Shared package ddr3_arb_pkg:
  - State encoding (S_INIT, S_IDLE, S_WR, S_RD).
  - Owner encoding (OWN_WR=0, OWN_RD=1).
  - RUN_CNT_MAX=15.
- One sub-module: ddr3_arb_watchdog (timeout counter, start/clear/expire), instantiated only under the macro.
- The FSM and weighted-priority selection stay in the top module.

Test Plan:
- Calibration gating: hold init_calib_complete=0 with both requests high for 100 cycles → no grant. Set it to 1 → wr_grant=1 two cycles later (S_INIT→S_IDLE, then grant).
- Weighted fairness: both requests stuck high, done pulse 10 cycles after each grant, weights 4/4 → grant sequence WR×4, RD×4, WR×4. Counters read 8/4 after 12 bursts.
- Sole requester: only rd_ddr3_req=1 for 20 bursts → 20 consecutive rd_grants. rd_burst_cnt=20, wr_burst_cnt=0.
- Stray and late events:
  - wr_burst_done pulsed during S_RD → ignored, no count.
  - Calibration drops mid-burst → grant held until done, then S_INIT.
- Reset mid-burst: reset_n low during wr_grant → all outputs 0 asynchronously. After release, state is S_INIT.
- Watchdog (macro on, TIMEOUT_CYCLES=64): grant with no done pulse → grant drops at cycle 64, err_timeout=1 and stays 1. The pending other requester is granted next.
